task_fifo_sched: RTL

Weighted round-robin read scheduler that shares one downstream task consumer among `NQ` per-tree task FIFOs. Each FIFO has 1-cycle registered read data that is only valid in the cycle after `rd_en`. The block issues at most one `rd_en` per cycle, to one FIFO. It captures the returned task one cycle later, tags it with its queue index and buffers it in a 4-entry output queue with a valid/ready handshake. It sits between the per-tree task FIFO bank and the task dispatch stage.

---
 rtl/task_fifo_sched.sv | 99 +++++++++
 1 files changed

// File: rtl/task_fifo_sched.sv
// task_fifo_sched: weighted round-robin read scheduler over NQ task FIFOs feeding a 4-entry tagged output queue.
// Ports: clk, rst_n (async, active-low); fifo_empty/fifo_rd_en/fifo_dout connect to the task FIFO bank
// (1-cycle registered read data); cfg_en/cfg_quantum set per-queue enable and max consecutive grants;
// out_valid/out_ready/out_data/out_qid hand tagged tasks to the dispatch stage; busy flags in-flight or queued work.
module task_fifo_sched #(
  parameter int NQ = 4,
  parameter int DW = 50,
  parameter int QW = 4,
  localparam int QIDW = $clog2(NQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NQ-1:0]      fifo_empty,
  output logic [NQ-1:0]      fifo_rd_en,
  input  logic [NQ*DW-1:0]   fifo_dout,
  input  logic [NQ-1:0]      cfg_en,
  input  logic [NQ*QW-1:0]   cfg_quantum,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DW-1:0]      out_data,
  output logic [QIDW-1:0]    out_qid,
  output logic               busy
);
  logic [QIDW-1:0] cur_q, cur_d, tag_q, tag_d, pick, idx, gidx;
  logic [QW-1:0]   gcnt_q, gcnt_d, quantum;
  logic            inflight_q, inflight_d, found, stay, grant, wr, pop;
  logic [2:0]      occ_q, occ_d;
  logic [1:0]      wptr_q, wptr_d, rptr_q, rptr_d;
  logic [NQ-1:0]   elig;
  logic [DW-1:0]   data_q [4];
  logic [DW-1:0]   data_d [4];
  logic [QIDW-1:0] qid_q [4];
  logic [QIDW-1:0] qid_d [4];

  assign out_valid = occ_q != 3'd0;
  assign out_data  = data_q[rptr_q];
  assign out_qid   = qid_q[rptr_q];
  assign busy      = inflight_q || out_valid;

  always_comb begin
    elig = cfg_en & ~fifo_empty;
    quantum = cfg_quantum[cur_q*QW +: QW];
    stay = elig[cur_q] && (gcnt_q < ((quantum == '0) ? QW'(1) : quantum));
    found = 1'b0;
    pick = cur_q;
    idx = cur_q;
    // scan cur+1 .. cur+NQ so the current queue is considered last
    for (int k = 1; k <= NQ; k++) begin
      idx = QIDW'((int'(cur_q) + k) % NQ);
      if (!found && elig[idx]) begin
        found = 1'b1;
        pick = idx;
      end
    end
    // rst_n gating keeps the strobe low while reset is held; credit ignores out_ready on purpose
    grant = rst_n && (({1'b0, occ_q} + {3'b0, inflight_q}) < 4'd4) && (stay || found);
    gidx = stay ? cur_q : pick;
    fifo_rd_en = grant ? (NQ'(1) << gidx) : '0;
    cur_d = grant ? gidx : cur_q;
    gcnt_d = grant ? (stay ? gcnt_q + QW'(1) : QW'(1)) : gcnt_q;
    inflight_d = grant;
    tag_d = grant ? gidx : tag_q;
    wr = inflight_q;
    pop = out_valid && out_ready;
    data_d = data_q;
    qid_d = qid_q;
    if (wr) begin
      data_d[wptr_q] = fifo_dout[tag_q*DW +: DW];
      qid_d[wptr_q] = tag_q;
    end
    wptr_d = wptr_q + 2'(wr);
    rptr_d = rptr_q + 2'(pop);
    occ_d = occ_q + 3'(wr) - 3'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_q <= '0;
      gcnt_q <= '0;
      inflight_q <= 1'b0;
      tag_q <= '0;
      occ_q <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      data_q <= '{default: '0};
      qid_q <= '{default: '0};
    end else begin
      cur_q <= cur_d;
      gcnt_q <= gcnt_d;
      inflight_q <= inflight_d;
      tag_q <= tag_d;
      occ_q <= occ_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      data_q <= data_d;
      qid_q <= qid_d;
    end
  end
endmodule
